serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 144 ++++++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. One operand bit pair is processed per clock, LSB first,
// through a single full adder and a carry flop. A WIDTH-bit operation takes
// WIDTH clocks after the accepting edge. The full result appears on S/C in a
// single update, marked by a one-cycle DONE pulse.
//
// Parameters
//   WIDTH  operand/result width in bits (1..32)
//
// Ports
//   CLK    clock, rising edge
//   RST_N  synchronous active-low reset
//   START  begin an operation; accepted whenever BUSY is low
//   A, B   operands, sampled only on the accepting edge
//   SUB    select A-B (only with SERIAL_ADDER_SUB_EN defined)
//   S, C   registered result and carry-out (no-borrow flag when subtracting)
//   BUSY   operation in progress
//   DONE   one-cycle pulse: S/C have just been updated
//
// Build option
//   SERIAL_ADDER_SUB_EN  adds the SUB port and subtract support
//                        (B inverted, carry flop seeded with 1).
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for START, S/C hold the last result
// RUN   | one result bit per clock, WIDTH clocks in total
// FIN   | S/C just updated, DONE high; START here restarts directly
//
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] bit_cnt;
    logic             carry_q;
    logic             sub_q;

    logic             b_bit;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;

`ifndef SERIAL_ADDER_SUB_EN
    // Add-only build: operand B is never inverted.
    assign sub_q = 1'b0;
`endif

    always_comb begin
        b_bit     = b_sh[0] ^ sub_q;
        sum_bit   = a_sh[0] ^ b_bit ^ carry_q;
        carry_nxt = (a_sh[0] & b_bit) | (a_sh[0] & carry_q) | (b_bit & carry_q);
    end

    // Sum bits are shifted into the top of the A register as A bits are
    // consumed from the bottom, so after WIDTH steps a_sh holds the result.
    generate
        if (WIDTH == 1) begin : g_w1
            assign a_nxt = sum_bit;
            assign b_nxt = 1'b0;
        end else begin : g_wn
            assign a_nxt = {sum_bit, a_sh[WIDTH-1:1]};
            assign b_nxt = {1'b0, b_sh[WIDTH-1:1]};
        end
    endgenerate

    assign BUSY = (state == ST_RUN);
    assign DONE = (state == ST_FIN);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            bit_cnt <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
            S       <= '0;
            C       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    if (START) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        bit_cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q   <= SUB;
                        carry_q <= SUB;
`else
                        carry_q <= 1'b0;
`endif
                        state   <= ST_RUN;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // START is deliberately not looked at here.
                    a_sh    <= a_nxt;
                    b_sh    <= b_nxt;
                    carry_q <= carry_nxt;
                    if (bit_cnt == CNT_LAST) begin
                        S     <= a_nxt;
                        C     <= carry_nxt;
                        state <= ST_FIN;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic [7:0] s;
    logic       c, busy, done;
    logic       sub8;

    logic       start1, a1, b1;
    logic       s1, c1, busy1, done1;
    logic       sub1;

    serial_adder #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub8),
`endif
        .S(s), .C(c), .BUSY(busy), .DONE(done)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .A(a1), .B(b1),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB(sub1),
`endif
        .S(s1), .C(c1), .BUSY(busy1), .DONE(done1)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] last_s;
    logic       last_c;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         sub;
        logic [7:0] s;
        logic       c;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 9-bit arithmetic, subtract as A + ~B + 1.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input bit sb);
        logic [7:0] ny;
        ny = ~y;
        if (sb) return {1'b0, x} + {1'b0, ny} + 9'd1;
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Runs one operation on the 8-bit DUT. inject_at >= 0 raises START with
    // A=0x01 at that sample inside the busy window, which must be ignored.
    task automatic do_op8(input string name, input logic [7:0] xa, input logic [7:0] xb,
                          input bit xs, input logic [7:0] es, input logic ec, input int inject_at);
        int cycles;
        int busy_cnt;
        bit held;
        @(negedge clk);
        a = xa; b = xb; sub8 = xs; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sub8 = 1'($urandom);
        cycles = 0; busy_cnt = 0; held = 1'b1;
        while (!done && cycles < 30) begin
            if (busy) busy_cnt++;
            if (s !== last_s || c !== last_c) held = 1'b0;
            if (cycles == inject_at) begin
                start = 1'b1; a = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check({name, " latency"}, cycles, 8);
        check({name, " busy_cycles"}, busy_cnt, 8);
        check({name, " s_held"}, {31'd0, held}, 1);
        check({name, " s"}, {24'd0, s}, {24'd0, es});
        check({name, " c"}, {31'd0, c}, {31'd0, ec});
        check({name, " busy_at_done"}, {31'd0, busy}, 0);
        last_s = es; last_c = ec;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; sub1 = 1'b0;
        last_s = '0; last_c = 1'b0;

        repeat (3) @(negedge clk);
        check("reset s", {24'd0, s}, 0);
        check("reset c", {31'd0, c}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset done", {31'd0, done}, 0);
        check("reset w1 s/c/busy/done", {28'd0, s1, c1, busy1, done1}, 0);
        rst_n = 1'b1;

        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h10, 8'h20, 1'b0, 8'h30, 1'b0});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0});
        vecs.push_back('{8'h07, 8'h05, 1'b1, 8'h02, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 8'h00, 1'b1});
`endif
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});

        foreach (vecs[i])
            do_op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].s, vecs[i].c, -1);

        // START during busy with a new A must not disturb the running op.
        do_op8("restart_ignored", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 2);

        // Reset mid-operation, with START asserted on the reset edge.
        begin
            int done_seen;
            @(negedge clk);
            a = 8'h33; b = 8'h44; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0; start = 1'b1;
            @(negedge clk);
            rst_n = 1'b1; start = 1'b0;
            check("midreset s", {24'd0, s}, 0);
            check("midreset c", {31'd0, c}, 0);
            check("midreset busy", {31'd0, busy}, 0);
            check("midreset done", {31'd0, done}, 0);
            done_seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done || busy) done_seen++;
            end
            check("midreset no_activity", done_seen, 0);
            last_s = '0; last_c = 1'b0;
            do_op8("after_reset", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, -1);
        end

        // START held high: a result every WIDTH+1 cycles.
        begin
            int idx, prev, ndone;
            @(negedge clk);
            a = 8'h10; b = 8'h20; sub8 = 1'b0; start = 1'b1;
            idx = 0; prev = 0; ndone = 0;
            while (ndone < 3 && idx < 60) begin
                @(negedge clk);
                idx++;
                if (done) begin
                    check($sformatf("b2b%0d s", ndone), {24'd0, s}, 32'h30);
                    check($sformatf("b2b%0d c", ndone), {31'd0, c}, 0);
                    check($sformatf("b2b%0d period", ndone), idx - prev, 9);
                    prev = idx;
                    ndone++;
                    if (ndone == 3) start = 1'b0;
                end
            end
            start = 1'b0;
            check("b2b pulses", ndone, 3);
            last_s = 8'h30; last_c = 1'b0;
        end

        // Randomised operations against the arithmetic model.
        for (int n = 0; n < 25; n++) begin
            logic [7:0] ra, rb;
            bit rs;
            logic [8:0] e;
            ra = 8'($urandom); rb = 8'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = model(ra, rb, rs);
            do_op8($sformatf("rand%0d", n), ra, rb, rs, e[7:0], e[8], -1);
        end

        // WIDTH=1: registered half adder.
        begin
            logic [1:0] exp_sc [4];
            exp_sc[0] = 2'b00; exp_sc[1] = 2'b10; exp_sc[2] = 2'b10; exp_sc[3] = 2'b01;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                a1 = k[1]; b1 = k[0]; sub1 = 1'b0; start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                check($sformatf("w1_%0d busy", k), {30'd0, busy1, done1}, 32'h2);
                @(negedge clk);
                check($sformatf("w1_%0d done", k), {31'd0, done1}, 1);
                check($sformatf("w1_%0d sc", k), {30'd0, s1, c1}, {30'd0, exp_sc[k]});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
